// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM state type and default geometry for the 2x2 pooling block
package pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int IMG_W_DEF = 6;
  localparam int IMG_H_DEF = 6;
endpackage

// File: rtl/max_pool_2x2_if.sv
// max_pool_2x2_if: raster sample stream in, pooled sample stream out
interface max_pool_2x2_if #(parameter int DATA_W = pool_pkg::DATA_W_DEF);
  logic in_st;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic out_st;
  logic frame_done;
  modport master (output in_st, din, input dout, out_st, frame_done);
  modport slave (input in_st, din, output dout, out_st, frame_done);
endinterface

// File: rtl/pool_reduce.sv
// pool_reduce: two-operand combine; unsigned max, or plain sum when POOL_AVG_EN is defined
module pool_reduce #(parameter int W = 16) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
`ifdef POOL_AVG_EN
  assign y_o = a_i + b_i;
`else
  assign y_o = (a_i > b_i) ? a_i : b_i;
`endif
endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 pooling over a raster frame; POOL_AVG_EN selects averaging
module max_pool_2x2 import pool_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input logic clk,
  input logic rst,
  max_pool_2x2_if.slave bus
);
`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LN = IMG_W / 2;
  localparam int LW = LN > 1 ? $clog2(LN) : 1;
  state_t state_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] hold_q, dout_q, pooled;
  logic out_st_q;
  logic [ACC_W-1:0] lb_q [LN];
  logic [ACC_W-1:0] pmax, res;
  logic [LW-1:0] lidx;
  logic acc, last_col, last, win;
  // Accept qualification, window completion and counter next-state
  always_comb begin
    acc = bus.in_st && !rst;
    last_col = col_q == CW'(IMG_W - 1);
    last = last_col && row_q == RW'(IMG_H - 1);
    win = acc && col_q[0] && row_q[0];
    col_d = last_col ? '0 : col_q + 1'b1;
    row_d = !last_col ? row_q : (last ? '0 : row_q + 1'b1);
    lidx = LW'(col_q >> 1);
  end
  pool_reduce #(.W(ACC_W)) u_pair (.a_i(ACC_W'(hold_q)), .b_i(ACC_W'(bus.din)), .y_o(pmax));
  pool_reduce #(.W(ACC_W)) u_vert (.a_i(pmax), .b_i(lb_q[lidx]), .y_o(res));
`ifdef POOL_AVG_EN
  assign pooled = res[ACC_W-1:2];
`else
  assign pooled = res;
`endif
  // Even-column sample is held for the pair; even-row pair results park in the line buffer
  always_ff @(posedge clk) begin
    if (acc && !col_q[0]) hold_q <= bus.din;
    if (acc && col_q[0] && !row_q[0]) lb_q[lidx] <= pmax;
  end
  // Frame FSM, raster counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      out_st_q <= 1'b0;
      dout_q <= '0;
    end else begin
      if (acc) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      out_st_q <= win;
      if (win) dout_q <= pooled;
      state_q <= acc ? (last ? DONE : RUN) : (state_q == DONE ? IDLE : state_q);
    end
  end
  assign bus.dout = dout_q;
  assign bus.out_st = out_st_q;
  assign bus.frame_done = state_q == DONE;
endmodule
